// File: rtl/midi_key_tracker.sv
// MIDI byte-stream parser with running status that tracks up to two held keys on one channel.
// Optional MIDI_ALL_NOTES_OFF_EN: CC 0x7B on CHANNEL clears both key slots.
module midi_key_tracker #(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter logic [6:0] KEY_LO  = 7'd48,
   parameter logic [6:0] KEY_HI  = 7'd78
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [6:0] key1_index,
   output logic [6:0] key2_index,
   output logic       midi_ready,
   output logic [7:0] drop_count
);

   typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

   state_e     state_q;
   logic [7:0] status_q;
   logic [6:0] d1_q;
   logic [6:0] key1_q, key2_q;
   logic [6:0] key1_d, key2_d;
   logic       ready_q;
   logic [7:0] drop_q;

   logic is_data, msg_done, chan_ok, key_ok, note_on, note_off, one_byte;

   assign is_data  = rx_valid & ~rx_byte[7];
   assign msg_done = is_data && (state_q == StWaitD2);
   assign chan_ok  = (status_q[3:0] == CHANNEL);
   assign key_ok   = (d1_q >= KEY_LO) && (d1_q <= KEY_HI);
   assign note_on  = (status_q[7:4] == 4'h9) && (rx_byte[6:0] != 7'd0);
   assign note_off = (status_q[7:4] == 4'h8) ||
                     ((status_q[7:4] == 4'h9) && (rx_byte[6:0] == 7'd0));
   assign one_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);

   // Next slot contents if the byte on rx_byte completes a message.
   always_comb begin
      key1_d = key1_q;
      key2_d = key2_q;
      if (msg_done && chan_ok) begin
         if (key_ok && note_on) begin
            if ((d1_q != key1_q) && (d1_q != key2_q)) begin
               if (key1_q == 7'd0) key1_d = d1_q;
               else                key2_d = d1_q;
            end
         end else if (key_ok && note_off) begin
            if (d1_q == key1_q) begin
               key1_d = key2_q;
               key2_d = 7'd0;
            end else if (d1_q == key2_q) begin
               key2_d = 7'd0;
            end
         end
`ifdef MIDI_ALL_NOTES_OFF_EN
         else if ((status_q[7:4] == 4'hB) && (d1_q == 7'h7B)) begin
            key1_d = 7'd0;
            key2_d = 7'd0;
         end
`endif
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         status_q <= 8'h00;
         d1_q     <= 7'd0;
         key1_q   <= 7'd0;
         key2_q   <= 7'd0;
         ready_q  <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         ready_q <= 1'b0;
         // Realtime bytes (0xF8-0xFF) fall through untouched, even mid-message.
         if (rx_valid && (rx_byte < 8'hF8)) begin
            if (rx_byte >= 8'hF0) begin
               status_q <= 8'h00;
               state_q  <= StIdle;
            end else if (rx_byte[7]) begin
               status_q <= rx_byte;
               state_q  <= StWaitD1;
            end else begin
               case (state_q)
                  StIdle: begin
                     if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                  end
                  StWaitD1: begin
                     d1_q <= rx_byte[6:0];
                     if (!one_byte) state_q <= StWaitD2;
                  end
                  StWaitD2: begin
                     state_q <= StWaitD1;
                     key1_q  <= key1_d;
                     key2_q  <= key2_d;
                     ready_q <= (key1_d != key1_q) || (key2_d != key2_q);
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   assign key1_index = key1_q;
   assign key2_index = key2_q;
   assign midi_ready = ready_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_midi_key_tracker.sv
// Randomised and directed bench for midi_key_tracker against a message-level reference model.
module tb_midi_key_tracker;

   localparam int Chan  = 0;
   localparam int KeyLo = 48;
   localparam int KeyHi = 78;

   logic       clock;
   logic       reset_n;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [6:0] key1_index;
   logic [6:0] key2_index;
   logic       midi_ready;
   logic [7:0] drop_count;

   midi_key_tracker dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .key1_index (key1_index),
      .key2_index (key2_index),
      .midi_ready (midi_ready),
      .drop_count (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: running status (-1 = none), collected data bytes, held keys oldest first.
   int rs;
   int data_q[$];
   int held[$];
   int drops;
   int exp_ready;

   function automatic int mk1();
      return (held.size() > 0) ? held[0] : 0;
   endfunction

   function automatic int mk2();
      return (held.size() > 1) ? held[1] : 0;
   endfunction

   task automatic model_reset();
      rs = -1;
      data_q.delete();
      held.delete();
      drops = 0;
      exp_ready = 0;
   endtask

   task automatic model_msg(input int st, input int d1, input int d2);
      int kind;
      bit in_range;
      kind = st >> 4;
      in_range = (d1 >= KeyLo) && (d1 <= KeyHi);
      if ((st & 15) != Chan) return;
      if (kind == 9 && d2 != 0 && in_range) begin
         bit found = 0;
         foreach (held[i]) if (held[i] == d1) found = 1;
         if (!found) begin
            if (held.size() < 2) held.push_back(d1);
            else held[1] = d1;
         end
      end else if ((kind == 8 || (kind == 9 && d2 == 0)) && in_range) begin
         for (int i = 0; i < held.size(); i++) begin
            if (held[i] == d1) begin
               held.delete(i);
               break;
            end
         end
      end
`ifdef MIDI_ALL_NOTES_OFF_EN
      else if (kind == 11 && d1 == 8'h7B) begin
         held.delete();
      end
`endif
   endtask

   task automatic model_byte(input int b);
      int k1, k2, need;
      k1 = mk1();
      k2 = mk2();
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
         rs = -1;
         data_q.delete();
      end else if (b >= 8'h80) begin
         rs = b;
         data_q.delete();
      end else if (rs < 0) begin
         if (drops < 255) drops++;
      end else begin
         data_q.push_back(b);
         need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
         if (data_q.size() == need) begin
            if (need == 2) model_msg(rs, data_q[0], data_q[1]);
            data_q.delete();
         end
      end
      exp_ready = (k1 != mk1() || k2 != mk2()) ? 1 : 0;
   endtask

   task automatic step(input bit v, input logic [7:0] b);
      @(negedge clock);
      rx_valid = v;
      rx_byte  = b;
      exp_ready = 0;
      if (v) model_byte(int'(b));
      @(posedge clock);
      #1;
      check("key1", int'(key1_index), mk1());
      check("key2", int'(key2_index), mk2());
      check("ready", int'(midi_ready), exp_ready);
      check("drops", int'(drop_count), drops);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b);
   endtask

   task automatic do_reset();
      @(negedge clock);
      rx_valid = 1'b0;
      reset_n  = 1'b0;
      model_reset();
      #1;
      check("rst_key1", int'(key1_index), 0);
      check("rst_key2", int'(key2_index), 0);
      check("rst_ready", int'(midi_ready), 0);
      check("rst_drops", int'(drop_count), 0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   logic [7:0] rb;
   int pulses;

   initial begin
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      model_reset();
      #12;
      do_reset();

      // Single note-on.
      send(8'h90); send(8'h3C); send(8'h40);
      check("tp1_key1", int'(key1_index), 60);
      check("tp1_ready", int'(midi_ready), 1);
      step(1'b0, 8'h00);
      check("tp1_ready_drop", int'(midi_ready), 0);

      // Running status second key, then release the first.
      send(8'h40); send(8'h50);
      check("tp2_key2", int'(key2_index), 64);
      send(8'h3C); send(8'h00);
      check("tp2_key1", int'(key1_index), 64);
      check("tp2_key2_off", int'(key2_index), 0);

      // Third key steals slot 2; repeat gives no pulse.
      do_reset();
      send(8'h90); send(8'h3C); send(8'h40); send(8'h40); send(8'h40);
      send(8'h90); send(8'h43); send(8'h40);
      check("tp3_key1", int'(key1_index), 60);
      check("tp3_key2", int'(key2_index), 67);
      send(8'h90); send(8'h43); send(8'h40);
      check("tp3_repeat_ready", int'(midi_ready), 0);

      // Filtering: other channel, out of range, program change.
      send(8'h91); send(8'h3C); send(8'h40);
      send(8'h90); send(8'h20); send(8'h40);
      send(8'hC0); send(8'h05); send(8'h3C); send(8'h40);
      check("tp4_key1", int'(key1_index), 60);
      check("tp4_key2", int'(key2_index), 67);

      // Realtime transparency, SysEx, saturation.
      do_reset();
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h40);
      check("tp5_key1", int'(key1_index), 60);
      send(8'hF0); send(8'h3C); send(8'h40);
      check("tp5_drops", int'(drop_count), 2);
      for (int i = 0; i < 300; i++) send(8'h7F);
      check("tp5_sat", int'(drop_count), 255);

      // Reset mid-message.
      do_reset();
      send(8'h90); send(8'h3C);
      do_reset();
      send(8'h40);
      check("tp6_drops", int'(drop_count), 1);
      check("tp6_key1", int'(key1_index), 0);

`ifdef MIDI_ALL_NOTES_OFF_EN
      do_reset();
      send(8'h90); send(8'h3C); send(8'h40); send(8'h40); send(8'h40);
      send(8'hB0); send(8'h7B); send(8'h00);
      check("tp7_key1", int'(key1_index), 0);
      check("tp7_key2", int'(key2_index), 0);
      check("tp7_ready", int'(midi_ready), 1);
`endif

      // Random traffic, with keys clustered so slots collide often.
      do_reset();
      pulses = 0;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 12) begin
            case ($urandom_range(0, 7))
               0, 1, 2: rb = 8'h90;
               3:       rb = 8'h80;
               4:       rb = 8'h91;
               5:       rb = 8'hB0;
               6:       rb = 8'hC0;
               default: rb = 8'(8'hA0 + 8'($urandom_range(0, 4)) * 8'h10);
            endcase
         end else if (r < 15) begin
            rb = 8'(8'hF0 + $urandom_range(0, 7));
         end else if (r < 19) begin
            rb = 8'(8'hF8 + $urandom_range(0, 7));
         end else if (r < 25) begin
            rb = (($urandom_range(0, 1)) != 0) ? 8'h7B : 8'h00;
         end else if (r < 30) begin
            rb = 8'($urandom_range(0, 127));
         end else begin
            rb = 8'($urandom_range(KeyLo - 2, KeyLo + 6));
         end
         step(($urandom_range(0, 9) != 0), rb);
         if (exp_ready != 0) pulses++;
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      check("rand_some_pulses", (pulses > 20) ? 1 : 0, 1);

      step(1'b0, 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/midi_key_tracker.md
Name: midi_key_tracker

Overview:
- Upstream producer of key1_index / key2_index / midi_ready for the game logic; sits between the MIDI UART receiver and the game logic.
- Parses the raw MIDI byte stream, including running status, on one channel.
- Tracks up to two held keys and pulses midi_ready exactly once per change in the held-key set.

Parameters:
- CHANNEL, 4'd0, MIDI channel accepted; channel voice messages on other channels are parsed and discarded.
- KEY_LO, 7'd48, lowest accepted note number; must be >= 1, since 0 encodes an empty slot.
- KEY_HI, 7'd78, highest accepted note number. Default gives key-48 in 0..30; 31 is reserved for "no key".

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_byte  in  8  received MIDI byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid; may be high every cycle
- key1_index  out  7  first held key; 0 = none
- key2_index  out  7  second held key; 0 = none
- midi_ready  out  1  one-cycle pulse, key slots changed
- drop_count  out  8  saturating count of discarded data bytes, i.e. data bytes seen with no running status

Behaviour:
- Reset (async, reset_n low): key1_index=0, key2_index=0, midi_ready=0, drop_count=0, parser in IDLE, running status cleared. Reset mid-message abandons the message.
- Byte classes, evaluated only when rx_valid=1:
  - 0xF8-0xFF (realtime): ignored completely, even mid-message. No state change.
  - 0xF0-0xF7 (system common/SysEx): clear running status, go to IDLE.
  - 0x80-0xEF (status): latch as running status, go to WAIT_D1. Any partial message is abandoned.
  - 0x00-0x7F (data): handled per state.
- Parser FSM states:
  - IDLE: data byte -> discard, drop_count+1, saturates at 255.
  - WAIT_D1: data byte -> latch d1. For 0xCn/0xDn status, message completes (discarded), go to WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2: data byte -> message complete, go to WAIT_D1 (running status kept).
- Completed message acted on only if status channel == CHANNEL and KEY_LO <= d1 <= KEY_HI:
  - Note-on (0x9n, velocity d2 != 0):
    - d1 already in a slot: no change.
    - else key1 empty -> key1=d1.
    - else key2 empty -> key2=d1.
    - else key2=d1 (newest steals slot 2).
  - Note-off (0x8n, or 0x9n with d2==0):
    - d1==key1 -> key1=key2, key2=0.
    - else d1==key2 -> key2=0.
    - else no change.
  - All other messages: no effect.
- Invariant: key2 != 0 implies key1 != 0, and key1 != key2 when both are nonzero.
- Timing: slot update and midi_ready=1 appear on the clock edge after the completing byte is sampled, i.e. outputs valid the cycle after rx_valid. midi_ready is high for exactly one cycle and only if either slot value changed.
- Back-to-back rx_valid every cycle: each byte processed; each completed message can pulse midi_ready independently.
- Data bits 7 of d1/d2 are always 0 by class; no width extension needed. Slot comparisons are 7-bit.

Optional Feature:
- Macro MIDI_ALL_NOTES_OFF_EN.
- Defined: control change 0xBn on CHANNEL with d1==0x7B (All Notes Off), any d2, clears both slots. midi_ready pulses only if either slot was nonzero. The KEY_LO/KEY_HI range check does not apply to this message.
- Undefined: every 0xBn message is parsed and discarded with no effect.

Test Plan:
- Reset then bytes 0x90,0x3C,0x40 -> next cycle key1=60, key2=0, midi_ready single pulse; drop_count=0.
- Running status: 0x90,0x3C,0x40,0x40,0x50 -> key1=60, key2=64, two midi_ready pulses. Then 0x3C,0x00 -> key1=64, key2=0, third pulse.
- Third key: hold 60, 64, then 0x90,0x43,0x40 -> key2=67, key1=60. Repeat 0x90,0x43,0x40 -> no midi_ready.
- Filtering:
  - 0x91,0x3C,0x40 (channel 1) -> no change.
  - 0x90,0x20,0x40 (key 32, below KEY_LO) -> no change.
  - 0xC0,0x05,0x3C,0x40 -> program change then running-status program change; no key change, no pulse.
- Interleaving: 0x90, 0xF8, 0x3C, 0xFE, 0x40 -> key1=60 (realtime transparent). Then 0xF0, 0x3C, 0x40 -> drop_count=2, no change. Then 0x7F x300 with no status -> drop_count saturates at 255.
- Reset mid-message: 0x90,0x3C, reset_n low 1 cycle, then 0x40 -> drop_count=1, keys 0. With MIDI_ALL_NOTES_OFF_EN: hold 60, 64, send 0xB0,0x7B,0x00 -> both slots 0, one pulse.
